// File: rtl/fp_mul_pkg.sv
// Shared types, flag bit positions and format helpers for the pipelined FP multiplier.
// Used by fp_mul_pipe and fp_mul_round.
package fp_mul_pkg;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_SUB,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    // Result override decided at unpack time and carried down the pipe
    typedef enum logic [1:0] {
        SPC_NONE,
        SPC_ZERO,
        SPC_INF,
        SPC_NAN
    } fp_special_e;

    localparam int FLAG_W         = 4;
    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;

    localparam int QNAN_MAX_W = 128;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB only
    function automatic logic [QNAN_MAX_W-1:0] qnan(input int exp_w, input int man_w);
        logic [QNAN_MAX_W-1:0] q;
        q = (((QNAN_MAX_W'(1) << exp_w) - QNAN_MAX_W'(1)) << man_w)
            | (QNAN_MAX_W'(1) << (man_w - 1));
        return q;
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Final-stage combinational logic: normalise, round-to-nearest-even, renormalise,
// overflow/underflow detection, special-case override and packing.
module fp_mul_round import fp_mul_pkg::*; #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                       sign,
    input  logic signed [EXP_W+1:0]    exp_sum,
    input  logic [2*MAN_W+1:0]         prod,
    input  fp_special_e                special,
    input  logic                       invalid,
    output logic [EXP_W+MAN_W:0]       result,
    output logic [FLAG_W-1:0]          flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic [QNAN_MAX_W-1:0] QNAN_FULL = qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]          QNAN      = QNAN_FULL[W-1:0];
    localparam logic signed [XW-1:0]  MAX_EXP   = XW'((1 << EXP_W) - 1);

    function automatic logic rne_up(input logic lsb, input logic g, input logic r,
                                    input logic s);
        return g & (r | s | lsb);
    endfunction

    logic                   msb;
    logic [PW-1:0]          norm;
    logic signed [XW-1:0]   exp_n;
    logic signed [XW-1:0]   exp_r;
    logic [MAN_W:0]         mant;
    logic                   g_bit;
    logic                   r_bit;
    logic                   s_bit;
    logic [MAN_W+1:0]       mant_r;
    logic                   carry;
    logic [MAN_W-1:0]       frac;
    logic                   overflow;
    logic                   underflow;

    // Product lies in [1,4): a set MSB means one right shift and exponent +1
    assign msb    = prod[PW-1];
    assign norm   = msb ? prod : (prod << 1);
    assign exp_n  = exp_sum + $signed({{(XW-1){1'b0}}, msb});
    assign mant   = norm[PW-1:MAN_W+1];
    assign g_bit  = norm[MAN_W];
    assign r_bit  = norm[MAN_W-1];
    assign s_bit  = |norm[MAN_W-2:0];
    assign mant_r = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rne_up(mant[0], g_bit, r_bit, s_bit)};
    assign carry  = mant_r[MAN_W+1];
    assign frac   = carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    assign exp_r  = exp_n + $signed({{(XW-1){1'b0}}, carry});

    assign overflow  = (exp_r >= MAX_EXP);
    assign underflow = exp_r[XW-1] || (exp_r == '0);

    always_comb begin
        result = {sign, exp_r[EXP_W-1:0], frac};
        flags  = '0;
        flags[FLAG_INEXACT] = g_bit | r_bit | s_bit;
        case (special)
            SPC_NAN: begin
                result = QNAN;
                flags  = '0;
                flags[FLAG_INVALID] = invalid;
            end
            SPC_INF: begin
                result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                flags  = '0;
            end
            SPC_ZERO: begin
                result = {sign, {(EXP_W+MAN_W){1'b0}}};
                flags  = '0;
            end
            default: begin
                if (overflow) begin
                    result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags[FLAG_OVERFLOW] = 1'b1;
                    flags[FLAG_INEXACT]  = 1'b1;
                end else if (underflow) begin
                    result = {sign, {(EXP_W+MAN_W){1'b0}}};
                    flags[FLAG_UNDERFLOW] = 1'b1;
                    flags[FLAG_INEXACT]   = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754-style multiplier with valid/ready flow control, RNE, DAZ/FTZ and tag.
// Define FPMUL_FLAGS_EN to add the {invalid,overflow,underflow,inexact} flags port.
module fp_mul_pipe import fp_mul_pkg::*; #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [TAG_W-1:0]         out_tag
`ifdef FPMUL_FLAGS_EN
    ,
    output logic [FLAG_W-1:0]        flags
`endif
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int PW     = 2 * MAN_W + 2;
    localparam int XW     = EXP_W + 2;
    localparam int SLICES = STAGES - 2;
    localparam int BIAS_I = bias(EXP_W);
    localparam logic signed [XW-1:0] BIAS = XW'(BIAS_I);

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0)
            return (f == '0) ? FP_ZERO : FP_SUB;
        if (&e)
            return (f == '0) ? FP_INF : FP_NAN;
        return FP_NORM;
    endfunction

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    logic                  sign_a, sign_b;
    logic [EXP_W-1:0]      exp_a, exp_b;
    logic [MAN_W-1:0]      frac_a, frac_b;
    fp_class_e             cls_a, cls_b;
    logic                  zero_a, zero_b, inf_a, inf_b, nan_any, inf_zero, snan_any;
    fp_special_e           spc_c;
    logic                  invalid_c;
    logic signed [XW-1:0]  exp_sum_c;

    assign {sign_a, exp_a, frac_a} = a;
    assign {sign_b, exp_b, frac_b} = b;
    assign cls_a = classify(exp_a, frac_a);
    assign cls_b = classify(exp_b, frac_b);

    // Subnormals are treated as zero everywhere, including inf*subnormal
    assign zero_a    = (cls_a == FP_ZERO) || (cls_a == FP_SUB);
    assign zero_b    = (cls_b == FP_ZERO) || (cls_b == FP_SUB);
    assign inf_a     = (cls_a == FP_INF);
    assign inf_b     = (cls_b == FP_INF);
    assign nan_any   = (cls_a == FP_NAN) || (cls_b == FP_NAN);
    assign inf_zero  = (inf_a && zero_b) || (zero_a && inf_b);
    assign snan_any  = ((cls_a == FP_NAN) && !frac_a[MAN_W-1]) ||
                       ((cls_b == FP_NAN) && !frac_b[MAN_W-1]);
    assign invalid_c = snan_any || inf_zero;
    assign exp_sum_c = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;

    always_comb begin
        spc_c = SPC_NONE;
        if (nan_any || inf_zero)
            spc_c = SPC_NAN;
        else if (inf_a || inf_b)
            spc_c = SPC_INF;
        else if (zero_a || zero_b)
            spc_c = SPC_ZERO;
    end

    // ---- stage 1 registers: unpacked operands and classification ----
    logic                  vld_p0;
    logic                  sign_p0;
    logic signed [XW-1:0]  exp_p0;
    logic [MAN_W:0]        man_a_p0, man_b_p0;
    fp_special_e           spc_p0;
    logic [TAG_W-1:0]      tag_p0;

    // ---- stage 2 (product) and extra register slices ----
    logic [SLICES-1:0]     vld_p1;
    logic [PW-1:0]         prod_p1 [SLICES];
    logic                  sign_p1 [SLICES];
    logic signed [XW-1:0]  exp_p1  [SLICES];
    fp_special_e           spc_p1  [SLICES];
    logic [TAG_W-1:0]      tag_p1  [SLICES];

    logic [PW-1:0]         prod_c;
    assign prod_c = PW'(man_a_p0) * PW'(man_b_p0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= '0;
        end else if (advance) begin
            vld_p0    <= in_valid;
            vld_p1[0] <= vld_p0;
            for (int k = 1; k < SLICES; k++)
                vld_p1[k] <= vld_p1[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            sign_p0    <= sign_a ^ sign_b;
            exp_p0     <= exp_sum_c;
            man_a_p0   <= {1'b1, frac_a};
            man_b_p0   <= {1'b1, frac_b};
            spc_p0     <= spc_c;
            tag_p0     <= in_tag;
            prod_p1[0] <= prod_c;
            sign_p1[0] <= sign_p0;
            exp_p1[0]  <= exp_p0;
            spc_p1[0]  <= spc_p0;
            tag_p1[0]  <= tag_p0;
            for (int k = 1; k < SLICES; k++) begin
                prod_p1[k] <= prod_p1[k-1];
                sign_p1[k] <= sign_p1[k-1];
                exp_p1[k]  <= exp_p1[k-1];
                spc_p1[k]  <= spc_p1[k-1];
                tag_p1[k]  <= tag_p1[k-1];
            end
        end
    end

    logic                  inv_last;
    logic [W-1:0]          round_result;
    logic [FLAG_W-1:0]     round_flags;

`ifdef FPMUL_FLAGS_EN
    logic                  inv_p0;
    logic                  inv_p1 [SLICES];

    always_ff @(posedge clk) begin
        if (advance) begin
            inv_p0    <= invalid_c;
            inv_p1[0] <= inv_p0;
            for (int k = 1; k < SLICES; k++)
                inv_p1[k] <= inv_p1[k-1];
        end
    end

    assign inv_last = inv_p1[SLICES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            flags <= '0;
        else if (advance)
            flags <= round_flags;
    end
`else
    logic unused_flag_bits;
    assign unused_flag_bits = ^{invalid_c, round_flags};
    assign inv_last = 1'b0;
`endif

    fp_mul_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign    (sign_p1[SLICES-1]),
        .exp_sum (exp_p1[SLICES-1]),
        .prod    (prod_p1[SLICES-1]),
        .special (spc_p1[SLICES-1]),
        .invalid (inv_last),
        .result  (round_result),
        .flags   (round_flags)
    );

    // ---- final stage: rounded, packed output register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
        end else if (advance) begin
            out_valid <= vld_p1[SLICES-1];
            result    <= round_result;
            out_tag   <= tag_p1[SLICES-1];
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: single precision (3 stages) and half precision (5 stages).
module tb_fp_mul_pipe;

    logic clk = 1'b0;
    logic rst;

    logic        sp_in_valid, sp_in_ready, sp_out_valid, sp_out_ready;
    logic [31:0] sp_a, sp_b, sp_result;
    logic [3:0]  sp_in_tag, sp_out_tag;
    logic        hp_in_valid, hp_in_ready, hp_out_valid, hp_out_ready;
    logic [15:0] hp_a, hp_b, hp_result;
    logic [3:0]  hp_in_tag, hp_out_tag;
`ifdef FPMUL_FLAGS_EN
    logic [3:0]  sp_flags, hp_flags;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_mul_pipe u_sp (
        .clk(clk), .rst(rst),
        .in_valid(sp_in_valid), .in_ready(sp_in_ready),
        .a(sp_a), .b(sp_b), .in_tag(sp_in_tag),
        .out_valid(sp_out_valid), .out_ready(sp_out_ready),
        .result(sp_result), .out_tag(sp_out_tag)
`ifdef FPMUL_FLAGS_EN
        , .flags(sp_flags)
`endif
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .STAGES(5), .TAG_W(4)) u_hp (
        .clk(clk), .rst(rst),
        .in_valid(hp_in_valid), .in_ready(hp_in_ready),
        .a(hp_a), .b(hp_b), .in_tag(hp_in_tag),
        .out_valid(hp_out_valid), .out_ready(hp_out_ready),
        .result(hp_result), .out_tag(hp_out_tag)
`ifdef FPMUL_FLAGS_EN
        , .flags(hp_flags)
`endif
    );

    task automatic run_sp(input logic [31:0] x, input logic [31:0] y, input logic [3:0] t,
                          output logic [31:0] r, output int lat, output logic [3:0] f,
                          output logic [3:0] rt);
        @(negedge clk);
        sp_a = x; sp_b = y; sp_in_tag = t; sp_in_valid = 1'b1; sp_out_ready = 1'b1;
        @(posedge clk); #1;
        sp_in_valid = 1'b0;
        lat = 1;
        while (!sp_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = sp_result; rt = sp_out_tag;
`ifdef FPMUL_FLAGS_EN
        f = sp_flags;
`else
        f = 4'b0;
`endif
    endtask

    task automatic run_hp(input logic [15:0] x, input logic [15:0] y,
                          output logic [15:0] r, output int lat);
        @(negedge clk);
        hp_a = x; hp_b = y; hp_in_tag = 4'h3; hp_in_valid = 1'b1; hp_out_ready = 1'b1;
        @(posedge clk); #1;
        hp_in_valid = 1'b0;
        lat = 1;
        while (!hp_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = hp_result;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (sp_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", sp_out_valid); end
        checks++; if (sp_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", sp_result); end
        checks++; if (sp_out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h want 0", sp_out_tag); end
        checks++; if (hp_out_valid !== 1'b0) begin errors++; $display("FAIL reset_hp_out_valid: got %b want 0", hp_out_valid); end
`ifdef FPMUL_FLAGS_EN
        checks++; if (sp_flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b want 0000", sp_flags); end
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (sp_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", sp_in_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] r; int lat; logic [3:0] f, rt;
        run_sp(32'h3F800000, 32'h3F800000, 4'h9, r, lat, f, rt);
        checks++; if (r !== 32'h3F800000) begin errors++; $display("FAIL one_times_one: got %h want 3f800000", r); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL sp_latency: got %0d want 3", lat); end
        checks++; if (rt !== 4'h9) begin errors++; $display("FAIL sp_tag: got %h want 9", rt); end
`ifdef FPMUL_FLAGS_EN
        checks++; if (f !== 4'b0000) begin errors++; $display("FAIL one_flags: got %b want 0000", f); end
`endif
    endtask

    task automatic test_normal();
        logic [31:0] r; int lat; logic [3:0] f, rt;
        run_sp(32'h40200000, 32'h40200000, 4'h1, r, lat, f, rt);
        checks++; if (r !== 32'h40C80000) begin errors++; $display("FAIL two_point_five_sq: got %h want 40c80000", r); end
        run_sp(32'h49742400, 32'h5368D4A5, 4'h2, r, lat, f, rt);
        checks++; if (r !== 32'h5D5E0B6B) begin errors++; $display("FAIL 1e6_times_1e12: got %h want 5d5e0b6b", r); end
`ifdef FPMUL_FLAGS_EN
        checks++; if (f !== 4'b0001) begin errors++; $display("FAIL 1e18_flags: got %b want 0001", f); end
`endif
        run_sp(32'hBF800000, 32'h40400000, 4'h3, r, lat, f, rt);
        checks++; if (r !== 32'hC0400000) begin errors++; $display("FAIL neg_sign: got %h want c0400000", r); end
    endtask

    task automatic test_rounding();
        logic [31:0] r; int lat; logic [3:0] f, rt;
        run_sp(32'h3F800001, 32'h3F800001, 4'h4, r, lat, f, rt);
        checks++; if (r !== 32'h3F800002) begin errors++; $display("FAIL sticky_round: got %h want 3f800002", r); end
`ifdef FPMUL_FLAGS_EN
        checks++; if (f !== 4'b0001) begin errors++; $display("FAIL sticky_flags: got %b want 0001", f); end
`endif
        run_sp(32'h3FC00001, 32'h3FC00001, 4'h5, r, lat, f, rt);
        checks++; if (r !== 32'h40100002) begin errors++; $display("FAIL round_up: got %h want 40100002", r); end
        run_sp(32'h3F800003, 32'h3FC00000, 4'h6, r, lat, f, rt);
        checks++; if (r !== 32'h3FC00004) begin errors++; $display("FAIL tie_to_even: got %h want 3fc00004", r); end
    endtask

    task automatic test_special();
        logic [31:0] r; int lat; logic [3:0] f, rt;
        run_sp(32'h7F000000, 32'h7F000000, 4'h7, r, lat, f, rt);
        checks++; if (r !== 32'h7F800000) begin errors++; $display("FAIL overflow: got %h want 7f800000", r); end
`ifdef FPMUL_FLAGS_EN
        checks++; if (f !== 4'b0101) begin errors++; $display("FAIL overflow_flags: got %b want 0101", f); end
`endif
        run_sp(32'h7F800000, 32'h00000000, 4'h8, r, lat, f, rt);
        checks++; if (r !== 32'h7FC00000) begin errors++; $display("FAIL inf_times_zero: got %h want 7fc00000", r); end
`ifdef FPMUL_FLAGS_EN
        checks++; if (f !== 4'b1000) begin errors++; $display("FAIL invalid_flags: got %b want 1000", f); end
`endif
        run_sp(32'h00800000, 32'h00800000, 4'h9, r, lat, f, rt);
        checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL underflow: got %h want 00000000", r); end
`ifdef FPMUL_FLAGS_EN
        checks++; if (f !== 4'b0011) begin errors++; $display("FAIL underflow_flags: got %b want 0011", f); end
`endif
        run_sp(32'hFF800000, 32'h40000000, 4'hA, r, lat, f, rt);
        checks++; if (r !== 32'hFF800000) begin errors++; $display("FAIL neg_inf: got %h want ff800000", r); end
        run_sp(32'h80000000, 32'h3F800000, 4'hB, r, lat, f, rt);
        checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL neg_zero: got %h want 80000000", r); end
        run_sp(32'h00400000, 32'hC0000000, 4'hC, r, lat, f, rt);
        checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL daz_subnormal: got %h want 80000000", r); end
        run_sp(32'h7F800001, 32'h3F800000, 4'hD, r, lat, f, rt);
        checks++; if (r !== 32'h7FC00000) begin errors++; $display("FAIL snan_in: got %h want 7fc00000", r); end
`ifdef FPMUL_FLAGS_EN
        checks++; if (f !== 4'b1000) begin errors++; $display("FAIL snan_flags: got %b want 1000", f); end
`endif
        run_sp(32'hFFC12345, 32'h3F800000, 4'hE, r, lat, f, rt);
        checks++; if (r !== 32'h7FC00000) begin errors++; $display("FAIL qnan_in: got %h want 7fc00000", r); end
`ifdef FPMUL_FLAGS_EN
        checks++; if (f !== 4'b0000) begin errors++; $display("FAIL qnan_flags: got %b want 0000", f); end
`endif
    endtask

    task automatic test_half();
        logic [15:0] r; int lat;
        run_hp(16'h3C00, 16'h3C00, r, lat);
        checks++; if (r !== 16'h3C00) begin errors++; $display("FAIL hp_one: got %h want 3c00", r); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL hp_latency: got %0d want 5", lat); end
        run_hp(16'h4100, 16'h4100, r, lat);
        checks++; if (r !== 16'h4640) begin errors++; $display("FAIL hp_2p5_sq: got %h want 4640", r); end
        run_hp(16'h3C01, 16'h3C01, r, lat);
        checks++; if (r !== 16'h3C02) begin errors++; $display("FAIL hp_round: got %h want 3c02", r); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic stall = 1'b0;
        logic [31:0] held_r = '0;
        logic [3:0] held_t = '0;
        logic [31:0] exp_r;
        while ((sent < 8 || got < 8) && cyc < 200) begin
            @(negedge clk);
            sp_out_ready = (cyc % 3 == 0);
            if (sent < 8) begin
                sp_in_valid = 1'b1;
                sp_a = 32'h40000000;
                sp_b = 32'h3F800000 + (sent << 19);
                sp_in_tag = sent[3:0];
            end else begin
                sp_in_valid = 1'b0;
            end
            #1;
            if (stall) begin
                checks++;
                if (sp_out_valid !== 1'b1 || sp_result !== held_r || sp_out_tag !== held_t) begin
                    errors++;
                    $display("FAIL b2b_hold: got v=%b %h tag %h want v=1 %h tag %h",
                             sp_out_valid, sp_result, sp_out_tag, held_r, held_t);
                end
            end
            if (sp_out_valid && sp_out_ready) begin
                exp_r = 32'h3F800000 + (got << 19) + 32'h00800000;
                checks++;
                if (sp_result !== exp_r || sp_out_tag !== got[3:0]) begin
                    errors++;
                    $display("FAIL b2b_order: got %h tag %h want %h tag %h",
                             sp_result, sp_out_tag, exp_r, got[3:0]);
                end
                got++;
            end
            stall  = sp_out_valid && !sp_out_ready;
            held_r = sp_result;
            held_t = sp_out_tag;
            if (sp_in_valid && sp_in_ready)
                sent++;
            cyc++;
            @(posedge clk);
        end
        @(negedge clk);
        sp_in_valid = 1'b0;
        sp_out_ready = 1'b1;
        checks++; if (got !== 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got); end
    endtask

    task automatic test_reset_inflight();
        int cnt;
        logic [31:0] seen;
        @(negedge clk);
        sp_out_ready = 1'b1;
        sp_a = 32'h3F800000; sp_b = 32'h3F800000; sp_in_tag = 4'h5; sp_in_valid = 1'b1;
        @(negedge clk);
        sp_b = 32'h40000000; sp_in_tag = 4'h6;
        @(negedge clk);
        sp_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (sp_out_valid !== 1'b1) begin errors++; $display("FAIL inflight_pre: got %b want 1", sp_out_valid); end
        rst = 1'b0;
        #1;
        checks++; if (sp_out_valid !== 1'b0) begin errors++; $display("FAIL async_drop_valid: got %b want 0", sp_out_valid); end
        checks++; if (sp_result !== 32'h0) begin errors++; $display("FAIL async_drop_result: got %h want 0", sp_result); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (sp_out_valid) cnt++;
        end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL discarded_results: got %0d want 0", cnt); end
        @(negedge clk);
        sp_a = 32'h3F800000; sp_b = 32'h40400000; sp_in_tag = 4'h7; sp_in_valid = 1'b1;
        @(negedge clk);
        sp_in_valid = 1'b0;
        cnt = 0;
        seen = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (sp_out_valid) begin cnt++; seen = sp_result; end
        end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL post_reset_count: got %0d want 1", cnt); end
        checks++; if (seen !== 32'h40400000) begin errors++; $display("FAIL post_reset_value: got %h want 40400000", seen); end
    endtask

    initial begin
        rst = 1'b0;
        sp_in_valid = 1'b0; sp_out_ready = 1'b1; sp_a = '0; sp_b = '0; sp_in_tag = '0;
        hp_in_valid = 1'b0; hp_out_ready = 1'b1; hp_a = '0; hp_b = '0; hp_in_tag = '0;
        test_reset();
        test_basic();
        test_normal();
        test_rounding();
        test_special();
        test_half();
        test_back_to_back();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
